booth4_arb: RTL and testbench

BOOTH4_ARB -- requirements
Module: booth4_arb

---
 rtl/booth4_arb.sv | 122 ++++++++++++
 tb/tb_booth4_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/booth4_arb.sv
// Two-requester arbiter sharing one radix-4 Booth 4x4 multiplier,
// with round-robin grant and an in-order result FIFO.

module booth4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] z_o
);

  logic [7:0] a_x;

  function automatic logic [7:0] pp(
    input logic [2:0] d,
    input logic [7:0] a
  );
    logic [7:0] r;
    r = '0;
    case (d)
      3'b001, 3'b010: r = a;
      3'b011:         r = a << 1;
      3'b100:         r = -(a << 1);
      3'b101, 3'b110: r = -a;
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign a_x = {{4{a_i[3]}}, a_i};
  assign z_o = pp({b_i[1:0], 1'b0}, a_x)
             + (pp(b_i[3:1], a_x) << 2);

endmodule

module booth4_arb #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid_i,
  input  logic [3:0] a0_i,
  input  logic [3:0] b0_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [3:0] a1_i,
  input  logic [3:0] b1_i,
  output logic       req1_ready_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_z_o,
  output logic       out_id_o,
  output logic       busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         wr_q, rd_q;
  logic                  last_q;
  logic [DEPTH-1:0][7:0] z_q;
  logic [DEPTH-1:0]      id_q;

  logic       grant0, grant1, not_full;
  logic       acc0, acc1, push, pop;
  logic [3:0] a_m, b_m;
  logic [7:0] prod;

  // last_q==1 means requester 1 went last, so 0 wins a tie
  assign grant0 = req0_valid_i
                & (~req1_valid_i | last_q);
  assign grant1 = req1_valid_i
                & (~req0_valid_i | ~last_q);

  assign not_full     = count_q < CW'(DEPTH);
  assign req0_ready_o = rst_n & grant0 & not_full;
  assign req1_ready_o = rst_n & grant1 & not_full;

  assign acc0 = req0_valid_i & req0_ready_o;
  assign acc1 = req1_valid_i & req1_ready_o;
  assign push = acc0 | acc1;
  assign pop  = out_valid_o & out_ready_i;

  assign a_m = grant1 ? a1_i : a0_i;
  assign b_m = grant1 ? b1_i : b0_i;

  booth4 u_mul (
    .a_i (a_m),
    .b_i (b_m),
    .z_o (prod)
  );

  assign count_d = count_q + CW'(push) - CW'(pop);

  assign out_valid_o = count_q != '0;
  assign out_z_o  = out_valid_o ? z_q[rd_q] : 8'h00;
  assign out_id_o = out_valid_o & id_q[rd_q];
  assign busy_o   = rst_n
                  & (req0_valid_i | req1_valid_i | out_valid_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      last_q  <= 1'b1;
      z_q     <= '0;
      id_q    <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        z_q[wr_q]  <= prod;
        id_q[wr_q] <= acc1;
        wr_q       <= wr_q + AW'(1);
        last_q     <= acc1;
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth4_arb.sv
// Directed bench for booth4_arb: product table, contention,
// backpressure, push/pop overlap and mid-operation reset.

module tb_booth4_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid_i, req1_valid_i;
  logic [3:0] a0_i, b0_i, a1_i, b1_i;
  logic       req0_ready_o, req1_ready_o;
  logic       out_valid_o, out_ready_i;
  logic [7:0] out_z_o;
  logic       out_id_o, busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth4_arb #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid_i),
    .a0_i         (a0_i),
    .b0_i         (b0_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .a1_i         (a1_i),
    .b1_i         (b1_i),
    .req1_ready_o (req1_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_z_o      (out_z_o),
    .out_id_o     (out_id_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] z;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b0, 4'h3, 4'hE, 8'hFA};
    vt[1]  = '{1'b1, 4'h8, 4'h8, 8'h40};
    vt[2]  = '{1'b0, 4'h7, 4'h8, 8'hC8};
    vt[3]  = '{1'b1, 4'h7, 4'h7, 8'h31};
    vt[4]  = '{1'b0, 4'h0, 4'h8, 8'h00};
    vt[5]  = '{1'b1, 4'hF, 4'hF, 8'h01};
    vt[6]  = '{1'b0, 4'h5, 4'h3, 8'h0F};
    vt[7]  = '{1'b1, 4'h8, 4'h7, 8'hC8};
    vt[8]  = '{1'b0, 4'h2, 4'hD, 8'hFA};
    vt[9]  = '{1'b1, 4'h4, 4'h4, 8'h10};
    vt[10] = '{1'b0, 4'h6, 4'hB, 8'hE2};

    rst_n = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b0;
    a0_i = 4'h0; b0_i = 4'h0; a1_i = 4'h0; b1_i = 4'h0;
    out_ready_i = 1'b1;
    cyc();
    chk("rst_ovalid", out_valid_o, 0);
    chk("rst_rdy0", req0_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_z", out_z_o, 0);
    chk("rst_id", out_id_o, 0);

    // contention from reset: 0 first, then alternate
    req0_valid_i = 1'b1; a0_i = 4'h3; b0_i = 4'h2;
    req1_valid_i = 1'b1; a1_i = 4'hE; b1_i = 4'h5;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("cont_rdy0_%0d", k), req0_ready_o, 8'((k % 2) == 0));
      chk($sformatf("cont_rdy1_%0d", k), req1_ready_o, 8'((k % 2) == 1));
      if (k > 0) begin
        chk($sformatf("cont_ov_%0d", k), out_valid_o, 1);
        chk($sformatf("cont_id_%0d", k), out_id_o, 8'((k - 1) % 2));
        chk($sformatf("cont_z_%0d", k), out_z_o,
            ((k - 1) % 2) == 0 ? 8'h06 : 8'hF6);
      end
      cyc();
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    cyc();
    cyc();
    chk("cont_drain", out_valid_o, 0);
    chk("idle_busy", busy_o, 0);

    // product table
    for (int i = 0; i < 11; i++) begin
      if (vt[i].id) begin
        req1_valid_i = 1'b1; a1_i = vt[i].a; b1_i = vt[i].b;
      end else begin
        req0_valid_i = 1'b1; a0_i = vt[i].a; b0_i = vt[i].b;
      end
      #1;
      chk($sformatf("tbl_rdy_%0d", i),
          vt[i].id ? req1_ready_o : req0_ready_o, 1);
      cyc();
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      #1;
      chk($sformatf("tbl_ov_%0d", i), out_valid_o, 1);
      chk($sformatf("tbl_z_%0d", i), out_z_o, vt[i].z);
      chk($sformatf("tbl_id_%0d", i), out_id_o, 8'(vt[i].id));
      cyc();
    end
    chk("tbl_empty", out_valid_o, 0);

    // backpressure, DEPTH=2
    out_ready_i = 1'b0;
    req0_valid_i = 1'b1; a0_i = 4'h1; b0_i = 4'h1;
    #1;
    chk("bp_rdy_a", req0_ready_o, 1);
    cyc();
    a0_i = 4'h2; b0_i = 4'h3;
    #1;
    chk("bp_rdy_b", req0_ready_o, 1);
    cyc();
    a0_i = 4'h3; b0_i = 4'h3;
    #1;
    chk("bp_rdy_full", req0_ready_o, 0);
    out_ready_i = 1'b1;
    #1;
    chk("bp_rdy_full_pop", req0_ready_o, 0);
    chk("bp_head0", out_z_o, 8'h01);
    req0_valid_i = 1'b0;
    cyc();
    chk("bp_head1", out_z_o, 8'h06);
    cyc();
    chk("bp_empty", out_valid_o, 0);
    req0_valid_i = 1'b1;
    #1;
    chk("bp_rdy_again", req0_ready_o, 1);
    cyc();
    req0_valid_i = 1'b0;
    #1;
    chk("bp_late_z", out_z_o, 8'h09);
    cyc();

    // push/pop overlap with one entry queued
    out_ready_i = 1'b0;
    req0_valid_i = 1'b1; a0_i = 4'h2; b0_i = 4'h2;
    cyc();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; a1_i = 4'hF; b1_i = 4'h3;
    out_ready_i = 1'b1;
    #1;
    chk("ov_rdy1", req1_ready_o, 1);
    chk("ov_head_old", out_z_o, 8'h04);
    cyc();
    req1_valid_i = 1'b0; out_ready_i = 1'b0;
    #1;
    chk("ov_head_new", out_z_o, 8'hFD);
    chk("ov_id_new", out_id_o, 1);
    cyc();
    chk("ov_stable_z", out_z_o, 8'hFD);
    chk("ov_stable_id", out_id_o, 1);
    out_ready_i = 1'b1;
    cyc();
    chk("ov_count1", out_valid_o, 0);

    // reset with two queued entries and requests pending
    out_ready_i = 1'b0;
    req0_valid_i = 1'b1; a0_i = 4'h1; b0_i = 4'h2;
    cyc();
    cyc();
    chk("mr_full", req0_ready_o, 0);
    req1_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mr_ovalid", out_valid_o, 0);
    chk("mr_rdy0", req0_ready_o, 0);
    chk("mr_rdy1", req1_ready_o, 0);
    chk("mr_busy", busy_o, 0);
    cyc();
    req1_valid_i = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("mr_post_rdy0", req0_ready_o, 1);
    chk("mr_post_ov", out_valid_o, 0);
    req1_valid_i = 1'b1;
    #1;
    chk("mr_tie_rdy0", req0_ready_o, 1);
    chk("mr_tie_rdy1", req1_ready_o, 0);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
